pe_row_scheduler: RTL and testbench
===================================

PE_ROW_SCHEDULER -- requirements
Module: pe_row_scheduler

Interface
REQ-001 SHALL have parameter NPIX_W, default 12, width of pixel count and index.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, output FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse launching a run.
REQ-006 SHALL have port num_pix  input  NPIX_W  output pixels in run, sampled on accepted start.
REQ-007 SHALL have port busy  output  1  high from accepted start until done.
REQ-008 SHALL have port done  output  1  one-cycle pulse at run end.
REQ-009 SHALL have port pe_issue  output  1  high in cycles driving a valid row into the 5-tap PE.
REQ-010 SHALL have port row_sel  output  3  kernel row (0..4) fed to the PE this cycle.
REQ-011 SHALL have port pix_idx  output  NPIX_W  output pixel being issued.
REQ-012 SHALL have port p_sum  input  25  signed PE result, 3-cycle fixed latency, no PE enable.
REQ-013 SHALL have port out_data  output  28  signed 5-row accumulated pixel result.
REQ-014 SHALL have port out_valid  output  1  out_data valid.
REQ-015 SHALL have port out_ready  input  1  downstream accepts when out_valid & out_ready.

Function
REQ-016 SHALL implement states IDLE, ISSUE, DRAIN.
REQ-017 SHALL in IDLE accept start; num_pix!=0 -> ISSUE, busy=1; num_pix==0 -> done pulse next cycle, stay IDLE, busy stays 0.
REQ-018 SHALL ignore start while busy.
REQ-019 SHALL in ISSUE emit rows 0,1,2,3,4 of pixel pix_idx on consecutive issue cycles, then pix_idx+1, row_sel restarting at 0.
REQ-020 SHALL begin a pixel (row 0) only when credits>0; credits = FIFO_DEPTH - fifo_count - pixels_in_flight; rows 1..4 of a started pixel are never stalled.
REQ-021 SHALL hold pe_issue=0, row_sel and pix_idx stable during credit stall.
REQ-022 SHALL transition ISSUE -> DRAIN after row 4 of pixel num_pix-1 issues.
REQ-023 SHALL track issue validity with a 3-stage shift register; when stage 3 valid, add sign-extended p_sum to the 28-bit accumulator.
REQ-024 SHALL clear accumulator at row-0 capture (load, not add) and push accumulator+p_sum into FIFO at row-4 capture.
REQ-025 SHALL never overflow FIFO; credit rule of REQ-020 guarantees space.
REQ-026 SHALL present FIFO head on out_data/out_valid; pop on out_valid & out_ready; push and pop same cycle allowed, count unchanged.
REQ-027 SHALL in DRAIN wait until shift register empty and FIFO empty, then assert done one cycle, busy=0, go IDLE.
REQ-028 SHALL give minimum latency of 8 cycles from first row issue to out_valid of that pixel (5 issues + 3 PE stages).
REQ-029 SHALL sustain one pixel per 5 cycles with out_ready held high.

Reset
REQ-030 SHALL on rst_n low asynchronously force state IDLE, busy, done, pe_issue, out_valid = 0, row_sel, pix_idx, out_data = 0, FIFO and shift register empty, accumulator 0.
REQ-031 SHALL on reset mid-run discard all in-flight and buffered pixels; no done is generated for the aborted run.
REQ-032 SHALL accept start in the first cycle after rst_n deassertion.

Configuration
REQ-033 SHALL, with PE_SEQ_SAT_EN defined, clamp each value pushed into the FIFO to signed 16-bit range [-32768, 32767], sign-extended to 28 bits on out_data.
REQ-034 SHALL, without PE_SEQ_SAT_EN, push the full 28-bit sum unmodified; no clamp logic present.

Verification
REQ-035 SHALL cover: start, num_pix=1, p_sum rows = 1,2,3,4,5, out_ready=1 -> out_valid 8 cycles after first issue, out_data=15, done after pop.
REQ-036 SHALL cover: num_pix=4, out_ready=1 -> pix_idx 0..3, 20 issue cycles contiguous, 4 outputs spaced 5 cycles.
REQ-037 SHALL cover: num_pix=6, out_ready=0 -> issue stops after 2 pixels (10 issues), FIFO holds 2; out_ready=1 resumes, all 6 delivered in order.
REQ-038 SHALL cover: p_sum=16777215 (max 25-bit) all 5 rows -> out_data=83886075 without macro; 32767 with PE_SEQ_SAT_EN; p_sum=-16777216 x5 -> -83886080 / -32768.
REQ-039 SHALL cover: num_pix=0 -> done 1 cycle after start, no pe_issue, busy never high; start pulse during busy -> ignored.
REQ-040 SHALL cover: rst_n low at row 2 of pixel 1 of num_pix=3 -> all outputs 0 immediately, no out_valid or done afterward, new start runs cleanly.

Source files
------------

// File: rtl/pe_row_scheduler_if.sv
// Handshake and data bundle between the row scheduler, its 5-tap PE and the
// downstream consumer.
interface pe_row_scheduler_if #(
  parameter int unsigned NPIX_W = 12
) ();
  logic                      start;
  logic [NPIX_W-1:0]         num_pix;
  logic                      busy;
  logic                      done;
  logic                      pe_issue;
  logic [2:0]                row_sel;
  logic [NPIX_W-1:0]         pix_idx;
  logic signed [24:0]        p_sum;
  logic signed [27:0]        out_data;
  logic                      out_valid;
  logic                      out_ready;

  modport slave (
    input  start, num_pix, p_sum, out_ready,
    output busy, done, pe_issue, row_sel, pix_idx, out_data, out_valid
  );

  modport master (
    output start, num_pix, p_sum, out_ready,
    input  busy, done, pe_issue, row_sel, pix_idx, out_data, out_valid
  );
endinterface

// File: rtl/pe_row_scheduler.sv
// Issues 5 kernel rows per output pixel into a fixed-latency PE, accumulates the
// results and buffers them in a credit-managed FIFO. Optional macro PE_SEQ_SAT_EN
// clamps pushed results to signed 16-bit.
module pe_row_scheduler #(
  parameter int unsigned NPIX_W     = 12,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic             clk,
  input logic             rst_n,
  pe_row_scheduler_if.slave bus
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e             state_q, state_d;
  logic [2:0]         row_q, row_d;
  logic [NPIX_W-1:0]  pix_q, pix_d;
  logic [NPIX_W-1:0]  num_q, num_d;
  logic               done_q, done_d;

  logic [2:0]         vld_q, first_q, last_q;
  logic signed [27:0] acc_q;

  logic signed [27:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_q, rd_q;
  logic [CntW-1:0]    cnt_q, infl_q;

  logic [CntW:0]      used;
  logic               credit_ok, issue, start_px, push, pop;
  logic signed [27:0] psum_ext, sum, push_data;

  // Credits cover both buffered results and pixels whose rows are still in the PE.
  assign used      = {1'b0, cnt_q} + {1'b0, infl_q};
  assign credit_ok = used < (CntW + 1)'(FIFO_DEPTH);
  assign issue     = (state_q == StIssue) && ((row_q != 3'd0) || credit_ok);
  assign start_px  = issue && (row_q == 3'd0);
  assign psum_ext  = {{3{bus.p_sum[24]}}, bus.p_sum};
  assign sum       = acc_q + psum_ext;
  assign push      = vld_q[2] && last_q[2];
  assign pop       = (cnt_q != '0) && bus.out_ready;

`ifdef PE_SEQ_SAT_EN
  always_comb begin
    push_data = sum;
    if (sum > 28'sd32767) begin
      push_data = 28'sd32767;
    end else if (sum < -28'sd32768) begin
      push_data = -28'sd32768;
    end
  end
`else
  assign push_data = sum;
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    pix_d   = pix_q;
    num_d   = num_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.num_pix != '0) begin
            state_d = StIssue;
            num_d   = bus.num_pix;
            pix_d   = '0;
            row_d   = 3'd0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StIssue: begin
        if (issue) begin
          if (row_q == 3'd4) begin
            row_d = 3'd0;
            if (pix_q == num_q - NPIX_W'(1)) begin
              state_d = StDrain;
            end else begin
              pix_d = pix_q + NPIX_W'(1);
            end
          end else begin
            row_d = row_q + 3'd1;
          end
        end
      end
      StDrain: begin
        if ((vld_q == 3'b000) && (cnt_q == '0)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      row_q   <= 3'd0;
      pix_q   <= '0;
      num_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      pix_q   <= pix_d;
      num_q   <= num_d;
      done_q  <= done_d;
    end
  end

  // Stage 3 lines up with the PE result of the row issued three cycles earlier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 3'b000;
      first_q <= 3'b000;
      last_q  <= 3'b000;
      acc_q   <= '0;
    end else begin
      vld_q   <= {vld_q[1:0], issue};
      first_q <= {first_q[1:0], start_px};
      last_q  <= {last_q[1:0], issue && (row_q == 3'd4)};
      if (vld_q[2]) begin
        acc_q <= first_q[2] ? psum_ext : sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      infl_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= wr_q + PtrW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
      unique case ({start_px, push})
        2'b10:   infl_q <= infl_q + CntW'(1);
        2'b01:   infl_q <= infl_q - CntW'(1);
        default: infl_q <= infl_q;
      endcase
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;
  assign bus.pe_issue  = issue;
  assign bus.row_sel   = row_q;
  assign bus.pix_idx   = pix_q;
  assign bus.out_valid = (cnt_q != '0);
  assign bus.out_data  = (cnt_q != '0) ? mem_q[rd_q] : '0;
endmodule

// File: tb/tb_pe_row_scheduler.sv
// Self-checking bench: PE model with 3-cycle latency, result scoreboard and
// directed runs covering flow control, saturation bounds, zero runs and reset abort.
module tb_pe_row_scheduler;
  localparam int unsigned NPIX_W = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pe_row_scheduler_if #(.NPIX_W(NPIX_W)) bus ();

  pe_row_scheduler #(.NPIX_W(NPIX_W), .FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int sb[$];

  int mode = 0;
  int cyc = 0;
  int issue_cnt = 0;
  int first_issue_cyc = 0;
  int last_issue_cyc = 0;
  int exp_row = 0;
  int exp_pix = 0;
  longint exp_acc = 0;
  int pipe1 = 0, pipe2 = 0, pipe3 = 0;
  int pops = 0;
  int done_cnt = 0;
  bit lat_en = 0, lat_seen = 0;
  bit space_en = 0;
  int last_pop_cyc = -1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pick(input int pix, input int row);
    case (mode)
      0:       return row + 1 + 10 * pix;
      1:       return 16777215;
      2:       return -16777216;
      default: return int'($urandom_range(0, 2000)) - 1000;
    endcase
  endfunction

  assign bus.p_sum = pipe3[24:0];

  // PE model plus issue-order checks and scoreboard push.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_row = 0;
      exp_pix = 0;
      exp_acc = 0;
      sb.delete();
      pipe1 <= 0;
      pipe2 <= 0;
      pipe3 <= 0;
    end else begin
      int v;
      cyc = cyc + 1;
      v = 0;
      if (bus.start && !bus.busy) begin
        exp_row = 0;
        exp_pix = 0;
      end
      if (bus.pe_issue) begin
        chk("row_sel", int'(bus.row_sel), exp_row);
        chk("pix_idx", int'(bus.pix_idx), exp_pix);
        v = pick(exp_pix, exp_row);
        issue_cnt++;
        if (exp_row == 0 && exp_pix == 0) first_issue_cyc = cyc;
        last_issue_cyc = cyc;
        if (exp_row == 0) exp_acc = v;
        else exp_acc = exp_acc + v;
        if (exp_row == 4) begin
`ifdef PE_SEQ_SAT_EN
          if (exp_acc > 32767) exp_acc = 32767;
          if (exp_acc < -32768) exp_acc = -32768;
`endif
          sb.push_back(int'(exp_acc));
          exp_row = 0;
          exp_pix++;
        end else begin
          exp_row++;
        end
      end
      pipe1 <= v;
      pipe2 <= pipe1;
      pipe3 <= pipe2;
    end
  end

  // Output monitor: the cycle observed here ends at posedge number cyc+1.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) done_cnt++;
      if (bus.out_valid && lat_en && !lat_seen) begin
        lat_seen = 1;
        chk("latency", cyc + 1 - first_issue_cyc, 8);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          chk("out_data", int'($signed(bus.out_data)), sb.pop_front());
        end
        if (space_en && last_pop_cyc >= 0) chk("out_spacing", cyc + 1 - last_pop_cyc, 5);
        last_pop_cyc = cyc + 1;
        pops++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int n);
    bus.start   = 1'b1;
    bus.num_pix = NPIX_W'(n);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd_ready, input string tag);
    int n;
    n = 0;
    while (!bus.done && n < budget) begin
      if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (n >= budget) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_busy_at_done"}, int'(bus.busy), 0);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    bus.out_ready = 1'b1;
    tick();
    chk({tag, "_done_one_cycle"}, int'(bus.done), 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_issue"}, int'(bus.pe_issue), 0);
    chk({tag, "_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_row"}, int'(bus.row_sel), 0);
    chk({tag, "_pix"}, int'(bus.pix_idx), 0);
    chk({tag, "_data"}, int'($signed(bus.out_data)), 0);
  endtask

  initial begin
    int i0, p0, d0, n;
    bus.start     = 1'b0;
    bus.num_pix   = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    chk_zero_outputs("reset");

    // Single pixel launched in the first cycle out of reset.
    mode   = 0;
    lat_en = 1;
    rst_n  = 1'b1;
    start_run(1);
    chk("t1_busy", int'(bus.busy), 1);
    wait_done(60, 0, "t1");
    chk("t1_latency_seen", int'(lat_seen), 1);
    lat_en = 0;

    // Four pixels back to back; a start mid-run must be ignored.
    i0 = issue_cnt;
    p0 = pops;
    space_en = 1;
    last_pop_cyc = -1;
    start_run(4);
    repeat (3) tick();
    start_run(2);
    wait_done(100, 0, "t2");
    space_en = 0;
    chk("t2_issues", issue_cnt - i0, 20);
    chk("t2_issue_span", last_issue_cyc - first_issue_cyc + 1, 20);
    chk("t2_pops", pops - p0, 4);

    // Backpressure: only two pixels may be issued into a full FIFO.
    i0 = issue_cnt;
    p0 = pops;
    bus.out_ready = 1'b0;
    start_run(6);
    repeat (40) tick();
    chk("t3_stalled_issues", issue_cnt - i0, 10);
    chk("t3_valid_held", int'(bus.out_valid), 1);
    chk("t3_stall_no_issue", int'(bus.pe_issue), 0);
    chk("t3_busy", int'(bus.busy), 1);
    bus.out_ready = 1'b1;
    wait_done(200, 0, "t3");
    chk("t3_pops", pops - p0, 6);

    // Extreme PE values.
    mode = 1;
    start_run(1);
    wait_done(60, 0, "t4max");
    mode = 2;
    start_run(1);
    wait_done(60, 0, "t4min");

    // Zero-length run.
    i0 = issue_cnt;
    start_run(0);
    chk("t5_done", int'(bus.done), 1);
    chk("t5_busy", int'(bus.busy), 0);
    tick();
    chk("t5_done_pulse", int'(bus.done), 0);
    chk("t5_issues", issue_cnt - i0, 0);

    // Random values with random backpressure.
    mode = 3;
    p0 = pops;
    start_run(5);
    wait_done(400, 1, "t6");
    chk("t6_pops", pops - p0, 5);

    // Abort at row 2 of pixel 1.
    mode = 0;
    start_run(3);
    n = 0;
    while (!(bus.pe_issue && bus.pix_idx == 1 && bus.row_sel == 2) && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("t7_reach_timeout", 0, 1);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("t7_abort");
    d0 = done_cnt;
    p0 = pops;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("t7_no_pops", pops - p0, 0);
    chk("t7_no_done", done_cnt - d0, 0);
    chk("t7_idle_valid", int'(bus.out_valid), 0);
    p0 = pops;
    start_run(2);
    wait_done(100, 0, "t7_rerun");
    chk("t7_rerun_pops", pops - p0, 2);

    chk("final_sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
